// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// result returned as {remainder, quotient} with a one-cycle div_ready pulse.
//
// state   | meaning
// IDLE    | waiting for start_div; operands latched on the accepting edge
// DIVZERO | divisor was zero; result forced to 0 on the next edge
// BUSY    | shifting/subtracting, one quotient bit per edge
// DONE    | result valid, div_ready high for this single cycle
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               start_div,
   input  logic               signed_div,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               div_ready
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DIVZERO = 2'd1;
   localparam logic [1:0] S_BUSY    = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0]   mag_a, mag_b, sub, q_fin;
   logic               ge;

   // rem_q holds the already-shifted partial remainder; dvd_q shifts dividend
   // bits out of the top while quotient bits enter at the bottom.
   always_comb begin
      mag_a = (signed_div && a[WIDTH-1]) ? -a : a;
      mag_b = (signed_div && b[WIDTH-1]) ? -b : b;
      ge    = (rem_q >= {1'b0, dvs_q});
      sub   = ge ? WIDTH'(rem_q - {1'b0, dvs_q}) : rem_q[WIDTH-1:0];
      q_fin = {dvd_q[WIDTH-2:0], ge};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start_div && !annul) begin
               dvs_d   = mag_b;
               rem_d   = {{WIDTH{1'b0}}, mag_a[WIDTH-1]};
               dvd_d   = {mag_a[WIDTH-2:0], 1'b0};
               qneg_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
               rneg_d  = signed_div & a[WIDTH-1];
               cnt_d   = '0;
               state_d = (b == '0) ? S_DIVZERO : S_BUSY;
            end
         end
         S_DIVZERO: begin
            if (annul) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_DONE;
               result_d = '0;
            end
         end
         S_BUSY: begin
            if (annul) begin
               state_d = S_IDLE;
            end else begin
               rem_d = {sub, dvd_q[WIDTH-1]};
               dvd_d = {dvd_q[WIDTH-2:0], ge};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d  = S_DONE;
                  result_d = {(rneg_q ? -sub : sub), (qneg_q ? -q_fin : q_fin)};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign result    = result_q;
   assign div_ready = (state_q == S_DONE);

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: hand-computed DIV/DIVU vectors, zero divisor,
// annul, mid-operation reset and back-to-back starts.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        start_div = 1'b0;
   logic        signed_div = 1'b0;
   logic        annul = 1'b0;
   logic [63:0] result;
   logic        div_ready;

   int n_checks = 0;
   int n_errors = 0;

   div_iter #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .a          (a),
      .b          (b),
      .start_div  (start_div),
      .signed_div (signed_div),
      .annul      (annul),
      .result     (result),
      .div_ready  (div_ready)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the negedge right after the accepting edge; lat counts edges since then.
   task automatic wait_ready(output int lat);
      lat = 0;
      while (!div_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic no_ready_for(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         seen |= div_ready;
      end
      check_val(tag, {63'b0, seen}, 64'd0);
   endtask

   task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic sgn, input logic [63:0] exp_res);
      int lat;
      int exp_lat;
      exp_lat = (bv == 32'd0) ? 1 : 32;
      @(negedge clk);
      a = av; b = bv; signed_div = sgn; start_div = 1'b1;
      @(negedge clk);
      start_div = 1'b0;
      a = ~av; b = bv + 32'h1234; signed_div = ~sgn;
      wait_ready(lat);
      check_val({tag, " lat"}, 64'(lat), 64'(exp_lat));
      check_val({tag, " res"}, result, exp_res);
      @(negedge clk);
      check_val({tag, " pulse"}, {63'b0, div_ready}, 64'd0);
   endtask

   initial begin
      int lat;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #20;
      check_val("rst result", result, 64'd0);
      check_val("rst ready", {63'b0, div_ready}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      do_div("divu 100/7",     32'd100,       32'd7,         1'b0, {32'd2, 32'd14});
      do_div("div -7/2",       32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
      do_div("div 7/-2",       32'd7,         32'hFFFFFFFE,  1'b1, {32'd1, 32'hFFFFFFFD});
      do_div("divu max/1",     32'hFFFFFFFF,  32'd1,         1'b0, {32'd0, 32'hFFFFFFFF});
      do_div("div ovf",        32'h80000000,  32'hFFFFFFFF,  1'b1, {32'd0, 32'h80000000});
      do_div("divu min/max",   32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000, 32'd0});
      do_div("div -100/-7",    32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, {32'hFFFFFFFE, 32'd14});
      do_div("divu max/16",    32'hFFFFFFFF,  32'h10,        1'b0, {32'hF, 32'h0FFFFFFF});
      do_div("div by0",        32'hFFFFFFF9,  32'd0,         1'b1, 64'd0);
      do_div("divu 9/4",       32'd9,         32'd4,         1'b0, {32'd1, 32'd2});
      do_div("divu by0",       32'd1234,      32'd0,         1'b0, 64'd0);
      do_div("divu 1000/3",    32'd1000,      32'd3,         1'b0, {32'd1, 32'd333});

      // annul at iteration 10: no pulse, result held
      @(negedge clk);
      a = 32'd77; b = 32'd5; signed_div = 1'b0; start_div = 1'b1;
      @(negedge clk);
      start_div = 1'b0;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      no_ready_for("annul no pulse", 45);
      check_val("annul res held", result, {32'd1, 32'd333});
      do_div("after annul",    32'd77,        32'd5,         1'b0, {32'd2, 32'd15});

      // annul wins over start in IDLE
      @(negedge clk);
      a = 32'd5; b = 32'd1; start_div = 1'b1; annul = 1'b1;
      @(negedge clk);
      start_div = 1'b0; annul = 1'b0;
      no_ready_for("idle annul", 40);

      // reset at iteration 20
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'h10; signed_div = 1'b0; start_div = 1'b1;
      @(negedge clk);
      start_div = 1'b0;
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_val("midrst result", result, 64'd0);
      check_val("midrst ready", {63'b0, div_ready}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      no_ready_for("midrst no pulse", 40);

      // back-to-back with start held high across DONE
      @(negedge clk);
      a = 32'd50; b = 32'd5; signed_div = 1'b0; start_div = 1'b1;
      @(negedge clk);
      a = 32'd3; b = 32'd3;
      wait_ready(lat);
      check_val("b2b1 lat", 64'(lat), 64'd32);
      check_val("b2b1 res", result, {32'd0, 32'd10});
      a = 32'hFFFFFF9C; b = 32'd7; signed_div = 1'b1;
      @(negedge clk);
      check_val("b2b1 pulse", {63'b0, div_ready}, 64'd0);
      @(negedge clk);
      start_div = 1'b0;
      a = 32'd1; b = 32'd1; signed_div = 1'b0;
      wait_ready(lat);
      check_val("b2b2 lat", 64'(lat), 64'd32);
      check_val("b2b2 res", result, {32'hFFFFFFFE, 32'hFFFFFFF2});
      @(negedge clk);
      check_val("b2b2 pulse", {63'b0, div_ready}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
